// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC update sequencer: FSM states, PC update
// kinds, PC-source mux selects and exception vector addresses.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        UPDATE,
        EXC_EPC,
        EXC_WAIT,
        EXC_LOAD
    } state_t;

    // Codes 6 and 7 are reserved and are treated as an invalid opcode.
    typedef enum logic [2:0] {
        OP_SEQ = 3'd0,
        OP_BEQ = 3'd1,
        OP_BNE = 3'd2,
        OP_J   = 3'd3,
        OP_JR  = 3'd4,
        OP_RTE = 3'd5
    } pc_op_t;

    typedef enum logic [1:0] {
        CAUSE_NONE,
        CAUSE_OPCODE,
        CAUSE_OVERFLOW
    } cause_t;

    localparam logic [2:0] PCMUX_A      = 3'b000;
    localparam logic [2:0] PCMUX_ULAOUT = 3'b001;
    localparam logic [2:0] PCMUX_SLAC   = 3'b010;
    localparam logic [2:0] PCMUX_EPC    = 3'b011;
    localparam logic [2:0] PCMUX_MDR    = 3'b100;
    localparam logic [2:0] PCMUX_ULARES = 3'b101;

    localparam logic [7:0] VEC_OPCODE   = 8'd253;
    localparam logic [7:0] VEC_OVERFLOW = 8'd254;

    localparam int EXC_WAIT_CYCLES = 2;

    function automatic logic [7:0] vecFor(input cause_t cause);
        return (cause == CAUSE_OPCODE) ? VEC_OPCODE : VEC_OVERFLOW;
    endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Sequences one PC update per start request: a single-cycle normal update, or a
// four-cycle exception path that saves EPC and loads PC from the vector byte.
module pc_sequencer
    import pc_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] pc_op,
    input  logic       zero,
    input  logic       opcode_exc,
    input  logic       overflow_exc,
    output logic [2:0] PCmux,
    output logic       PCwrite,
    output logic       EPCwrite,
    output logic       vec_rd,
    output logic [7:0] vec_addr,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] WAIT_LOAD = 2'(EXC_WAIT_CYCLES - 1);

    state_t      r_state;
    logic [2:0]  r_op;
    logic        r_zero;
    cause_t      r_cause;
    logic [1:0]  r_waitCnt;
    cause_t      w_cause;

    // Invalid opcode outranks overflow when both are flagged.
    always_comb begin
        w_cause = CAUSE_NONE;
        if (opcode_exc || (pc_op >= 3'd6))
            w_cause = CAUSE_OPCODE;
        else if (overflow_exc)
            w_cause = CAUSE_OVERFLOW;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_op      <= 3'd0;
            r_zero    <= 1'b0;
            r_cause   <= CAUSE_NONE;
            r_waitCnt <= 2'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op    <= pc_op;
                        r_zero  <= zero;
                        r_cause <= w_cause;
                        r_state <= (w_cause == CAUSE_NONE) ? UPDATE : EXC_EPC;
                    end
                end
                UPDATE: r_state <= IDLE;
                EXC_EPC: begin
                    r_waitCnt <= WAIT_LOAD;
                    r_state   <= EXC_WAIT;
                end
                EXC_WAIT: begin
                    if (r_waitCnt == 2'd0)
                        r_state <= EXC_LOAD;
                    else
                        r_waitCnt <= r_waitCnt - 2'd1;
                end
                EXC_LOAD: r_state <= IDLE;
                default:  r_state <= IDLE;
            endcase
        end
    end

    // Outputs depend only on flops, so reset reaches them without waiting for a clock.
    always_comb begin
        PCmux    = PCMUX_ULARES;
        PCwrite  = 1'b0;
        EPCwrite = 1'b0;
        vec_rd   = 1'b0;
        vec_addr = 8'd0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            UPDATE: begin
                busy = 1'b1;
                done = 1'b1;
                case (r_op)
                    OP_SEQ: begin PCmux = PCMUX_ULARES; PCwrite = 1'b1;    end
                    OP_BEQ: begin PCmux = PCMUX_ULAOUT; PCwrite = r_zero;  end
                    OP_BNE: begin PCmux = PCMUX_ULAOUT; PCwrite = !r_zero; end
                    OP_J:   begin PCmux = PCMUX_SLAC;   PCwrite = 1'b1;    end
                    OP_JR:  begin PCmux = PCMUX_A;      PCwrite = 1'b1;    end
                    OP_RTE: begin PCmux = PCMUX_EPC;    PCwrite = 1'b1;    end
                    default: begin PCmux = PCMUX_ULARES; PCwrite = 1'b0;   end
                endcase
            end
            EXC_EPC: begin
                busy     = 1'b1;
                EPCwrite = 1'b1;
                vec_rd   = 1'b1;
                vec_addr = vecFor(r_cause);
            end
            EXC_WAIT: begin
                busy     = 1'b1;
                vec_rd   = 1'b1;
                vec_addr = vecFor(r_cause);
            end
            EXC_LOAD: begin
                busy    = 1'b1;
                PCmux   = PCMUX_MDR;
                PCwrite = 1'b1;
                done    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand-written
// corner sequences, and randomized transactions against a cycle-trace model.
module tb_pc_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] pc_op;
    logic       zero;
    logic       opcode_exc;
    logic       overflow_exc;
    logic [2:0] PCmux;
    logic       PCwrite;
    logic       EPCwrite;
    logic       vec_rd;
    logic [7:0] vec_addr;
    logic       busy;
    logic       done;

    int compCount = 0;
    int failCount = 0;

    pc_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .pc_op        (pc_op),
        .zero         (zero),
        .opcode_exc   (opcode_exc),
        .overflow_exc (overflow_exc),
        .PCmux        (PCmux),
        .PCwrite      (PCwrite),
        .EPCwrite     (EPCwrite),
        .vec_rd       (vec_rd),
        .vec_addr     (vec_addr),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle layout: PCmux[15:13] PCwrite[12] EPCwrite[11] vec_rd[10] vec_addr[9:2] busy[1] done[0]
    localparam logic [15:0] IDLE_OUT  = {3'b101, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
    localparam logic [15:0] MASK_ALL  = 16'hFFFF;
    localparam logic [15:0] MASK_NOVA = 16'hFC03;
    localparam logic [15:0] MASK_NOMX = 16'h1FFF;

    typedef struct {
        logic [2:0] op;
        logic       z;
        logic       opc;
        logic       ovf;
        logic [2:0] expMux;
        logic       expWrite;
        int         expLat;
        logic [7:0] expVec;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [15:0] getOut();
        return {PCmux, PCwrite, EPCwrite, vec_rd, vec_addr, busy, done};
    endfunction

    // Expected output bundle k cycles after the accepting edge, from the instruction-level rules.
    function automatic void modelAt(input logic [2:0] op, input logic z, input logic opc,
                                    input logic ovf, input int k,
                                    output logic [15:0] expOut, output logic [15:0] mask);
        logic [2:0] muxOf [6] = '{3'd5, 3'd1, 3'd1, 3'd2, 3'd0, 3'd3};
        logic       badOp = opc || (op >= 3'd6);
        logic       isExc = badOp || ovf;
        logic [7:0] vec   = badOp ? 8'd253 : 8'd254;
        logic       wr;
        expOut = IDLE_OUT;
        mask   = MASK_ALL;
        if (!isExc && k == 1) begin
            wr = (op == 3'd1) ? z : (op == 3'd2) ? !z : 1'b1;
            expOut = {muxOf[op], wr, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1};
            mask   = MASK_NOVA;
        end else if (isExc && k >= 1 && k <= 3) begin
            expOut = {3'd0, 1'b0, (k == 1), 1'b1, vec, 1'b1, 1'b0};
            mask   = MASK_NOMX;
        end else if (isExc && k == 4) begin
            expOut = {3'd4, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1};
            mask   = MASK_NOVA;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act,
                               input logic [15:0] expv, input logic [15:0] mask);
        compCount++;
        if ((act & mask) !== (expv & mask)) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h (mask %h)", name, act & mask, expv & mask, mask);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic scrambleInputs(input logic allowStart);
        pc_op        = 3'($urandom);
        zero         = 1'($urandom);
        opcode_exc   = 1'($urandom);
        overflow_exc = 1'($urandom);
        start        = allowStart ? 1'($urandom) : 1'b0;
    endtask

    // Presents a request for one edge, then leaves garbage on the inputs; ends in cycle +1.
    task automatic applyStimulus(input logic [2:0] op, input logic z, input logic opc, input logic ovf);
        pc_op        = op;
        zero         = z;
        opcode_exc   = opc;
        overflow_exc = ovf;
        start        = 1'b1;
        stepCycle();
        scrambleInputs(1'b0);
    endtask

    task automatic addVec(input logic [2:0] op, input logic z, input logic opc, input logic ovf,
                          input logic [2:0] m, input logic w, input int lat, input logic [7:0] v);
        vec_t e;
        e.op = op; e.z = z; e.opc = opc; e.ovf = ovf;
        e.expMux = m; e.expWrite = w; e.expLat = lat; e.expVec = v;
        vecs.push_back(e);
    endtask

    initial begin
        logic [15:0] expOut;
        logic [15:0] mask;
        int          doneCount;
        int          writeCount;

        reset = 1'b1;
        start = 1'b0;
        pc_op = 3'd0;
        zero = 1'b0;
        opcode_exc = 1'b0;
        overflow_exc = 1'b0;
        #3;
        checkOutput("reset_idle", getOut(), IDLE_OUT, MASK_ALL);
        stepCycle();
        reset = 1'b0;
        stepCycle();

        addVec(3'd0, 1'b0, 1'b0, 1'b0, 3'b101, 1'b1, 1, 8'd0);
        addVec(3'd1, 1'b1, 1'b0, 1'b0, 3'b001, 1'b1, 1, 8'd0);
        addVec(3'd1, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1, 8'd0);
        addVec(3'd2, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 1, 8'd0);
        addVec(3'd2, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 1, 8'd0);
        addVec(3'd3, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 1, 8'd0);
        addVec(3'd4, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1, 8'd0);
        addVec(3'd5, 1'b0, 1'b0, 1'b0, 3'b011, 1'b1, 1, 8'd0);
        addVec(3'd0, 1'b0, 1'b1, 1'b1, 3'b100, 1'b1, 4, 8'd253);
        addVec(3'd7, 1'b0, 1'b0, 1'b0, 3'b100, 1'b1, 4, 8'd253);
        addVec(3'd6, 1'b1, 1'b0, 1'b1, 3'b100, 1'b1, 4, 8'd253);
        addVec(3'd0, 1'b0, 1'b0, 1'b1, 3'b100, 1'b1, 4, 8'd254);
        addVec(3'd3, 1'b1, 1'b0, 1'b1, 3'b100, 1'b1, 4, 8'd254);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].z, vecs[i].opc, vecs[i].ovf);
            for (int k = 1; k <= vecs[i].expLat; k++) begin
                if (vecs[i].expLat == 4 && k == 1)
                    checkOutput($sformatf("vec%0d_epc", i), {13'd0, EPCwrite, vec_rd, PCwrite},
                                {13'd0, 1'b1, 1'b1, 1'b0}, MASK_ALL);
                if (vecs[i].expLat == 4 && k < 4)
                    checkOutput($sformatf("vec%0d_vaddr_k%0d", i, k), {8'd0, vec_addr},
                                {8'd0, vecs[i].expVec}, MASK_ALL);
                if (k == vecs[i].expLat)
                    checkOutput($sformatf("vec%0d_final", i), {11'd0, PCmux, PCwrite, done},
                                {11'd0, vecs[i].expMux, vecs[i].expWrite, 1'b1}, MASK_ALL);
                scrambleInputs(1'b1);
                stepCycle();
            end
            start = 1'b0;
            checkOutput($sformatf("vec%0d_idle", i), getOut(), IDLE_OUT, MASK_ALL);
        end

        // A start pulsed while the exception is waiting must not produce a second update.
        doneCount  = 0;
        writeCount = 0;
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            if (done) doneCount++;
            if (PCwrite) writeCount++;
            pc_op = 3'd0;
            opcode_exc = 1'b0;
            overflow_exc = 1'b0;
            start = (k == 2 || k == 3);
            stepCycle();
        end
        start = 1'b0;
        checkOutput("busy_start_done_count", 16'(doneCount), 16'd1, MASK_ALL);
        checkOutput("busy_start_write_count", 16'(writeCount), 16'd1, MASK_ALL);

        // Reset in EXC_WAIT aborts immediately and leaves no pending write.
        applyStimulus(3'd1, 1'b1, 1'b1, 1'b0);
        stepCycle();
        checkOutput("abort_in_wait", getOut(), {3'd0, 1'b0, 1'b0, 1'b1, 8'd253, 1'b1, 1'b0}, MASK_NOMX);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("abort_same_cycle", getOut(), IDLE_OUT, MASK_ALL);
        stepCycle();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("abort_quiet_%0d", k), getOut(), IDLE_OUT, MASK_ALL);
            stepCycle();
        end

        // First edge after reset release accepts a request.
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b0);
        modelAt(3'd0, 1'b0, 1'b0, 1'b0, 1, expOut, mask);
        checkOutput("post_reset_seq", getOut(), expOut, mask);
        stepCycle();
        checkOutput("post_reset_idle", getOut(), IDLE_OUT, MASK_ALL);

        // Randomized transactions, with stray starts while busy.
        for (int t = 0; t < 80; t++) begin
            logic [2:0] op;
            logic       z, opc, ovf;
            int         len;
            op  = 3'($urandom);
            z   = 1'($urandom);
            opc = ($urandom_range(0, 7) == 0);
            ovf = ($urandom_range(0, 4) == 0);
            len = (opc || op >= 3'd6 || ovf) ? 4 : 1;
            applyStimulus(op, z, opc, ovf);
            for (int k = 1; k <= len + 1; k++) begin
                modelAt(op, z, opc, ovf, k, expOut, mask);
                checkOutput($sformatf("rand%0d_op%0d_k%0d", t, op, k), getOut(), expOut, mask);
                scrambleInputs(k <= len);
                if (k <= len) stepCycle();
            end
            if ($urandom_range(0, 3) == 0) stepCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", compCount, failCount);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request from the main control unit to perform this instruction's PC update.
REQ-005 pc_op  input  3  PC update kind, sampled with start.
REQ-006 zero  input  1  ALU zero flag, sampled with start.
REQ-007 opcode_exc  input  1  invalid-opcode flag, sampled with start.
REQ-008 overflow_exc  input  1  ALU overflow flag, sampled with start.
REQ-009 PCmux  output  3  select for the 6-input PC-source mux: 000 A, 001 ULAout, 010 SLAC, 011 EPCout, 100 MDRout, 101 ulaResult.
REQ-010 PCwrite  output  1  PC register load enable.
REQ-011 EPCwrite  output  1  EPC register load enable.
REQ-012 vec_rd  output  1  memory read strobe for the exception-vector byte.
REQ-013 vec_addr  output  8  exception-vector byte address.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 done  output  1  one-cycle pulse in the cycle PCwrite is asserted for the final update.

Function
REQ-016 The FSM SHALL have states IDLE, UPDATE, EXC_EPC, EXC_WAIT and EXC_LOAD.
REQ-017 In IDLE: PCmux=101; PCwrite, EPCwrite, vec_rd, busy and done=0; vec_addr=0.
REQ-018 With start=1 in IDLE: pc_op, zero and the exception cause are captured into registers; later input changes SHALL have no effect.
REQ-019 Exception priority: opcode_exc or reserved pc_op (6, 7) → cause=opcode, vec_addr=253; else overflow_exc → cause=overflow, vec_addr=254; else no exception.
REQ-020 From IDLE with start and no exception → UPDATE; with an exception → EXC_EPC.
REQ-021 UPDATE lasts 1 cycle, sets done=1, then returns to IDLE, so PCwrite comes 1 cycle after start.
REQ-022 UPDATE drives PCmux and PCwrite from the captured pc_op: SEQ(0) → 101, write; BEQ(1) → 001, write only if zero=1; BNE(2) → 001, write only if zero=0; J(3) → 010, write; JR(4) → 000, write; RTE(5) → 011, write.
REQ-023 For a branch not taken, PCwrite=0 and done=1.
REQ-024 EXC_EPC lasts 1 cycle: EPCwrite=1, vec_rd=1, vec_addr=cause vector.
REQ-025 EXC_EPC → EXC_WAIT.
REQ-026 EXC_WAIT holds vec_rd=1 and vec_addr for EXC_WAIT_CYCLES=2 cycles, counted by a 2-bit down-counter, then → EXC_LOAD.
REQ-027 EXC_LOAD lasts 1 cycle: PCmux=100, PCwrite=1, done=1; then → IDLE.
REQ-028 Total exception latency from start to PCwrite SHALL be 4 cycles.
REQ-029 start while busy=1 SHALL be ignored; it is neither queued nor flagged.
REQ-030 start in the same cycle the FSM returns to IDLE SHALL be ignored; it is accepted only when the state is IDLE.
REQ-031 All outputs SHALL be decoded from the state and captured registers only, never from live inputs.

Reset
REQ-032 reset SHALL force IDLE, clear the captured registers and the counter, and drive the IDLE output values of REQ-017 immediately.
REQ-033 Reset during any state SHALL abort the sequence with no further PCwrite or EPCwrite.
REQ-034 After reset deasserts, the first rising edge SHALL accept start.

Structure
REQ-035 Package pc_seq_pkg SHALL hold the state enum, the pc_op enum, the PCmux select constants, VEC_OPCODE=8'd253, VEC_OVERFLOW=8'd254 and EXC_WAIT_CYCLES=2.
REQ-036 The block SHALL be a single module with no sub-module; the wait counter is inline.

Verification
REQ-037 Scenario: start with pc_op=SEQ → the next cycle has PCmux=101, PCwrite=1, done=1; then IDLE.
REQ-038 Scenario: BEQ with zero=1, then BEQ with zero=0 → PCmux=001 with PCwrite=1, then PCwrite=0 with done=1.
REQ-039 Scenario: start with opcode_exc=1 and overflow_exc=1 → EPCwrite at +1, vec_addr=253 for cycles +1..+3, PCmux=100 with PCwrite at +4.
REQ-040 Scenario: pc_op=7 with no flags → same as the opcode exception with vec_addr=253; overflow only → vec_addr=254.
REQ-041 Scenario: start pulsed during EXC_WAIT → ignored; exactly one done pulse.
REQ-042 Scenario: reset asserted in EXC_WAIT → outputs return to IDLE values the same cycle; no PCwrite follows; a new SEQ start is handled normally.
